ins_dec_rv32i_pipe: RTL and testbench

//  Full RV32I base-ISA field decoder (R/I/S/B/U/J) for the decode stage, between fetch and register read.

---
 rtl/ins_dec_rv32i_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_ins_dec_rv32i_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_dec_rv32i_pipe.sv
// RV32I decode stage: registered field/immediate decoder with valid/ready and a 1-entry skid buffer.
// Optional illegal-encoding flag is built when INS_DEC_ILLEGAL_CHECK_EN is defined.
module ins_dec_rv32i_pipe #(
  parameter int XLEN  = 32,
  parameter int FMT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_ins_i,
  input  logic [XLEN-1:0]  in_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [6:0]       out_op_o,
  output logic [2:0]       out_funct3_o,
  output logic [6:0]       out_funct7_o,
  output logic [4:0]       out_rs1_o,
  output logic [4:0]       out_rs2_o,
  output logic [4:0]       out_rd_o,
  output logic [XLEN-1:0]  out_imm_o,
  output logic [FMT_W-1:0] out_fmt_o,
  output logic [XLEN-1:0]  out_pc_o,
  output logic             out_illegal_o
);

  localparam logic [FMT_W-1:0] FMT_R   = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_I   = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_S   = FMT_W'(2);
  localparam logic [FMT_W-1:0] FMT_B   = FMT_W'(3);
  localparam logic [FMT_W-1:0] FMT_U   = FMT_W'(4);
  localparam logic [FMT_W-1:0] FMT_J   = FMT_W'(5);
  localparam logic [FMT_W-1:0] FMT_UNK = FMT_W'(7);

  typedef struct packed {
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
  } dec_t;

  localparam dec_t DEC_RST = '{fmt: FMT_UNK, default: '0};

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t        d;
    logic [31:0] imm32;
    d     = DEC_RST;
    imm32 = '0;
    d.op  = ins[6:0];
    case (ins[6:0])
      7'b0110011:                                                 d.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: d.fmt = FMT_I;
      7'b0100011:                                                 d.fmt = FMT_S;
      7'b1100011:                                                 d.fmt = FMT_B;
      7'b0110111, 7'b0010111:                                     d.fmt = FMT_U;
      7'b1101111:                                                 d.fmt = FMT_J;
      default:                                                    d.fmt = FMT_UNK;
    endcase
    case (d.fmt)
      FMT_I: begin
        d.funct3 = ins[14:12]; d.rs1 = ins[19:15]; d.rd = ins[11:7];
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      FMT_S: begin
        d.funct3 = ins[14:12]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      FMT_B: begin
        d.funct3 = ins[14:12]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      FMT_U: begin
        d.rd  = ins[11:7];
        imm32 = {ins[31:12], 12'h000};
      end
      FMT_J: begin
        d.rd  = ins[11:7];
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: begin
        // R and unknown opcodes both expose the raw register/funct fields, no immediate
        d.funct3 = ins[14:12]; d.funct7 = ins[31:25];
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
      end
    endcase
    d.imm = XLEN'($signed(imm32));
    return d;
  endfunction

  dec_t            out_q, out_d, dec_src;
  logic [XLEN-1:0] pc_q, pc_d, skid_pc_q, skid_pc_d, src_pc;
  logic [31:0]     skid_ins_q, skid_ins_d, src_ins;
  logic            valid_q, valid_d, skid_full_q, skid_full_d;
  logic            accept, load_out;

  assign in_ready_o = ~skid_full_q;
  assign accept     = in_valid_i & in_ready_o;
  assign load_out   = ~valid_q | out_ready_i;
  assign src_ins    = skid_full_q ? skid_ins_q : in_ins_i;
  assign src_pc     = skid_full_q ? skid_pc_q : in_pc_i;
  assign dec_src    = decode(src_ins);

  always_comb begin
    out_d       = out_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    skid_full_d = skid_full_q;
    skid_ins_d  = skid_ins_q;
    skid_pc_d   = skid_pc_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
    end else if (load_out) begin
      // skid full implies in_ready=0, so no accept can compete with the drain
      if (skid_full_q || accept) begin
        out_d   = dec_src;
        pc_d    = src_pc;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
      skid_full_d = 1'b0;
    end else if (accept) begin
      skid_full_d = 1'b1;
      skid_ins_d  = in_ins_i;
      skid_pc_d   = in_pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q       <= DEC_RST;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      skid_full_q <= 1'b0;
      skid_ins_q  <= '0;
      skid_pc_q   <= '0;
    end else begin
      out_q       <= out_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      skid_full_q <= skid_full_d;
      skid_ins_q  <= skid_ins_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

`ifdef INS_DEC_ILLEGAL_CHECK_EN
  function automatic logic illegal_chk(input logic [31:0] ins, input logic [FMT_W-1:0] fmt);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    f3  = ins[14:12];
    f7  = ins[31:25];
    ill = (ins[1:0] != 2'b11) || (fmt == FMT_UNK);
    case (ins[6:0])
      7'b0000011: if (f3 inside {3'd3, 3'd6, 3'd7}) ill = 1'b1;
      7'b0100011: if (f3 > 3'd2) ill = 1'b1;
      7'b1100011: if (f3 inside {3'd2, 3'd3}) ill = 1'b1;
      7'b1100111: if (f3 != 3'd0) ill = 1'b1;
      7'b0110011: begin
        if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
        if (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) ill = 1'b1;
      end
      7'b0010011: begin
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
      end
      default: ;
    endcase
    return ill;
  endfunction

  logic ill_q, ill_d;

  always_comb begin
    ill_d = ill_q;
    if (!flush_i && load_out && (skid_full_q || accept)) ill_d = illegal_chk(src_ins, dec_src.fmt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ill_q <= 1'b0;
    else       ill_q <= ill_d;
  end

  assign out_illegal_o = ill_q;
`else
  assign out_illegal_o = 1'b0;
`endif

  assign out_valid_o  = valid_q;
  assign out_op_o     = out_q.op;
  assign out_funct3_o = out_q.funct3;
  assign out_funct7_o = out_q.funct7;
  assign out_rs1_o    = out_q.rs1;
  assign out_rs2_o    = out_q.rs2;
  assign out_rd_o     = out_q.rd;
  assign out_imm_o    = out_q.imm;
  assign out_fmt_o    = out_q.fmt;
  assign out_pc_o     = pc_q;

endmodule

// File: tb/tb_ins_dec_rv32i_pipe.sv
// Self-checking bench for ins_dec_rv32i_pipe: directed vectors plus a scoreboarded random stream.
module tb_ins_dec_rv32i_pipe;
  localparam int XLEN = 32;
`ifdef INS_DEC_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_ins, in_pc, out_imm, out_pc;
  logic [6:0]  out_op, out_funct7;
  logic [2:0]  out_funct3, out_fmt;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  ins_dec_rv32i_pipe #(.XLEN(XLEN), .FMT_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ins_i(in_ins), .in_pc_i(in_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_op_o(out_op), .out_funct3_o(out_funct3), .out_funct7_o(out_funct7),
    .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_rd_o(out_rd),
    .out_imm_o(out_imm), .out_fmt_o(out_fmt), .out_pc_o(out_pc), .out_illegal_o(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t       e;
    logic [2:0] f;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    e  = '0;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'h33:                             f = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: f = 3'd1;
      7'h23:                             f = 3'd2;
      7'h63:                             f = 3'd3;
      7'h37, 7'h17:                      f = 3'd4;
      7'h6F:                             f = 3'd5;
      default:                           f = 3'd7;
    endcase
    e.op     = w[6:0];
    e.pc     = pc;
    e.fmt    = f;
    e.rd     = (f inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd7}) ? w[11:7]  : 5'd0;
    e.rs1    = (f inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd7}) ? w[19:15] : 5'd0;
    e.rs2    = (f inside {3'd0, 3'd2, 3'd3, 3'd7})       ? w[24:20] : 5'd0;
    e.funct3 = (f inside {3'd4, 3'd5}) ? 3'd0 : f3;
    e.funct7 = (f inside {3'd0, 3'd7}) ? f7 : 7'd0;
    case (f)
      3'd1:    e.imm = {{20{w[31]}}, w[31:20]};
      3'd2:    e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    e.imm = {w[31:12], 12'h000};
      3'd5:    e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: e.imm = 32'd0;
    endcase
    bad = (w[1:0] != 2'b11) || (f == 3'd7);
    if (w[6:0] == 7'h03 && (f3 == 3'd3 || f3 >= 3'd6)) bad = 1'b1;
    if (w[6:0] == 7'h23 && f3 > 3'd2) bad = 1'b1;
    if (w[6:0] == 7'h63 && f3[2:1] == 2'b01) bad = 1'b1;
    if (w[6:0] == 7'h67 && f3 != 3'd0) bad = 1'b1;
    if (w[6:0] == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) bad = 1'b1;
    if (w[6:0] == 7'h13 && f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
    if (w[6:0] == 7'h13 && f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) bad = 1'b1;
    e.ill = ILL_EN & bad;
    return e;
  endfunction

  function automatic exp_t observed();
    return '{op: out_op, funct3: out_funct3, funct7: out_funct7, rs1: out_rs1, rs2: out_rs2,
             rd: out_rd, imm: out_imm, fmt: out_fmt, pc: out_pc, ill: out_illegal};
  endfunction

  // scoreboard: push on accept, compare head while valid (covers hold stability), pop on consume
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_spurious got pc=%h fmt=%0d, expected no output", out_pc, out_fmt);
        end else if (observed() !== sb[0]) begin
          errors++;
          $display("FAIL sb_bundle got %h expected %h", observed(), sb[0]);
        end
        if (out_ready && sb.size() > 0) void'(sb.pop_front());
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(in_ins, in_pc));
    end
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ins = '0; in_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_handshake got valid/ready=%b expected 01", {out_valid, in_ready});
    end
    checks++;
    if ({out_fmt, out_imm, out_pc, out_rd, out_rs1, out_rs2, out_op, out_illegal} !== {3'd7, 32'd0, 32'd0, 15'd0, 7'd0, 1'b0}) begin
      errors++; $display("FAIL reset_data got fmt=%0d imm=%h pc=%h expected fmt=7 imm=0 pc=0", out_fmt, out_imm, out_pc);
    end
  endtask

  task automatic test_addi();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_ins = 32'hFFF10093; in_pc = 32'h100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_latency got out_valid=%b expected 1", out_valid); end
    checks++;
    if ({out_fmt, out_op, out_rd, out_rs1, out_rs2, out_funct7, out_imm, out_pc} !==
        {3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 7'd0, 32'hFFFFFFFF, 32'h100}) begin
      errors++; $display("FAIL addi_fields got fmt=%0d rd=%0d rs1=%0d imm=%h expected fmt=1 rd=1 rs1=2 imm=ffffffff", out_fmt, out_rd, out_rs1, out_imm);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sw_lui();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_ins = 32'h00532423; in_pc = 32'h200;
    @(posedge clk); #1;
    in_ins = 32'h123451B7; in_pc = 32'h204;
    checks++;
    if ({out_fmt, out_rs1, out_rs2, out_rd, out_funct3, out_imm} !== {3'd2, 5'd6, 5'd5, 5'd0, 3'd2, 32'd8}) begin
      errors++; $display("FAIL sw_fields got fmt=%0d rs1=%0d rs2=%0d imm=%h expected fmt=2 rs1=6 rs2=5 imm=8", out_fmt, out_rs1, out_rs2, out_imm);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_fmt, out_rd, out_funct3, out_rs1, out_imm} !== {1'b1, 3'd4, 5'd3, 3'd0, 5'd0, 32'h12345000}) begin
      errors++; $display("FAIL lui_fields got v=%b fmt=%0d rd=%0d imm=%h expected v=1 fmt=4 rd=3 imm=12345000", out_valid, out_fmt, out_rd, out_imm);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_jal();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_ins = 32'hFFDFF06F; in_pc = 32'h280;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_fmt, out_rd, out_imm} !== {1'b1, 3'd5, 5'd0, 32'hFFFFFFFC}) begin
      errors++; $display("FAIL jal_fields got v=%b fmt=%0d rd=%0d imm=%h expected v=1 fmt=5 rd=0 imm=fffffffc", out_valid, out_fmt, out_rd, out_imm);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [31:0] words [3];
    logic        bad   [3];
    words = '{32'h00000000, 32'h0000B003, 32'h002081B3};
    bad   = '{1'b1, 1'b1, 1'b0};
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_ins = words[i]; in_pc = 32'h500 + 32'(4 * i);
      @(posedge clk); #1;
      checks++;
      if (out_illegal !== (ILL_EN & bad[i])) begin
        errors++; $display("FAIL illegal_%0d got %b expected %b for ins %h", i, out_illegal, ILL_EN & bad[i], words[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_skid();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_ins = 32'h00100093; in_pc = 32'h400;
    @(posedge clk); #1;
    in_ins = 32'h00200113; in_pc = 32'h404;
    @(posedge clk); #1;
    in_ins = 32'h00300193; in_pc = 32'h408;
    checks++;
    if ({out_valid, in_ready, out_pc} !== {2'b10, 32'h400}) begin
      errors++; $display("FAIL skid_fill got v=%b rdy=%b pc=%h expected v=1 rdy=0 pc=400", out_valid, in_ready, out_pc);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, out_pc} !== {2'b10, 32'h400}) begin
      errors++; $display("FAIL skid_hold got v=%b rdy=%b pc=%h expected v=1 rdy=0 pc=400", out_valid, in_ready, out_pc);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, out_pc} !== {2'b11, 32'h404}) begin
      errors++; $display("FAIL skid_drain got v=%b rdy=%b pc=%h expected v=1 rdy=1 pc=404", out_valid, in_ready, out_pc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 32'h408}) begin
      errors++; $display("FAIL skid_third got v=%b pc=%h expected v=1 pc=408", out_valid, out_pc);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got v=%b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_ins = 32'h00100093; in_pc = 32'h600;
    @(posedge clk); #1;
    in_ins = 32'h00200113; in_pc = 32'h604;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++; $display("FAIL flush_setup got v/rdy=%b expected 10", {out_valid, in_ready});
    end
    flush = 1'b1; in_ins = 32'h00300193; in_pc = 32'h608;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_clear got v/rdy=%b expected 01", {out_valid, in_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet_%0d got v=%b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      w = $urandom;
      if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 9)];
      in_ins    = w;
      in_pc     = 32'h1000 + 32'(4 * c);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d pending expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sw_lui();
    test_jal();
    test_illegal();
    test_skid();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
